// File: rtl/fir_wb_pkg.sv
// fir_wb_pkg: shared Wishbone offsets, status bit positions, FSM states and byte-lane helper
package fir_wb_pkg;
    localparam logic [7:0] ADDR_X_IN       = 8'h80;
    localparam logic [7:0] ADDR_SIN_STATUS = 8'h88;
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OCC_LSB = 2;
    localparam int ST_LAST    = 5;
    localparam int ST_CNT_LSB = 16;

    typedef enum logic [1:0] {IDLE, WAIT_SPACE, ACK} wb_state_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        for (int i = 0; i < 4; i++) lane_mask[i*8 +: 8] = {8{sel[i]}};
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, din      : write request and data (ignored when full)
//   pop, dout      : read request (ignored when empty) and head entry
//   empty, full    : status flags
//   occupancy      : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   occupancy
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    // the extra pointer MSB separates full (MSBs differ) from empty (equal)
    assign occupancy = wp - rp;
    assign empty     = wp == rp;
    assign full      = occupancy == (AW+1)'(DEPTH);
    assign dout      = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wp[AW-1:0]] <= din;
                wp              <= wp + 1'b1;
            end
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/wb_axis_in_fifo.sv
// wb_axis_in_fifo: Wishbone slave feeding the FIR X[n] AXI-Stream input through a small FIFO
//   axis_clk, axis_rst_n : clock, asynchronous active-low reset
//   wbs_*                : Wishbone slave (0x80 write X[n], 0x88 read status)
//   data_length          : samples per frame; 0 disables tlast
//   ap_start             : pulse restarting the frame counter
//   ss_tvalid/tdata/tlast/tready : stream to the FIR
module wb_axis_in_fifo
    import fir_wb_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic [CNT_WIDTH-1:0]   data_length,
    input  logic                   ap_start,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready
);
    localparam int OW = $clog2(FIFO_DEPTH) + 1;

    wb_state_t              state, state_nxt;
    logic                   req, x_wr, go_ack, wr_pend, tag, last_sticky;
    logic                   empty, full, pop;
    logic [OW-1:0]          occ;
    logic [CNT_WIDTH-1:0]   push_cnt;
    logic [pDATA_WIDTH-1:0] wdata;
    logic [pDATA_WIDTH:0]   head;
    logic [31:0]            status;
    logic                   unused_ok;

    assign unused_ok = &{1'b0, wbs_adr_i[31:8]};
    assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign x_wr      = wbs_we_i & (wbs_adr_i[7:0] == ADDR_X_IN);
    assign wbs_ack_o = state == ACK;
    assign pop       = ss_tvalid & ss_tready;
    assign ss_tvalid = ~empty;
    assign ss_tlast  = head[pDATA_WIDTH];
    assign ss_tdata  = head[pDATA_WIDTH-1:0];
    assign tag       = (data_length != '0) && (push_cnt == data_length - 1'b1);

    always_comb begin
        status                       = '0;
        status[ST_EMPTY]             = empty;
        status[ST_FULL]              = full;
        status[ST_OCC_LSB +: 3]      = 3'(occ);
        status[ST_LAST]              = last_sticky;
        status[ST_CNT_LSB +: 16]     = 16'(push_cnt);
    end

    always_comb begin
        state_nxt = state;
        go_ack    = 1'b0;
        case (state)
            IDLE:
                if (req) begin
                    if (x_wr && full) state_nxt = WAIT_SPACE;
                    else begin
                        state_nxt = ACK;
                        go_ack    = 1'b1;
                    end
                end
            WAIT_SPACE:
                if (!(wbs_cyc_i && wbs_stb_i)) state_nxt = IDLE;
                else if (!full) begin
                    state_nxt = ACK;
                    go_ack    = 1'b1;
                end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state <= IDLE;
        else             state <= state_nxt;
    end

    // Data is latched when the ack is scheduled and pushed on the edge that ends the ack
    // cycle, so the stream never sees a combinational path from the bus.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_pend   <= 1'b0;
            wdata     <= '0;
            wbs_dat_o <= '0;
        end else begin
            wr_pend   <= go_ack & x_wr;
            wbs_dat_o <= (go_ack && !wbs_we_i && wbs_adr_i[7:0] == ADDR_SIN_STATUS) ? status : '0;
            if (go_ack) wdata <= pDATA_WIDTH'(wbs_dat_i & lane_mask(wbs_sel_i));
        end
    end

    // ap_start wins over a simultaneous push; the push still tags with the old count
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            push_cnt    <= '0;
            last_sticky <= 1'b0;
        end else if (ap_start) begin
            push_cnt    <= '0;
            last_sticky <= 1'b0;
        end else if (wr_pend) begin
            push_cnt    <= tag ? '0 : push_cnt + 1'b1;
            last_sticky <= last_sticky | tag;
        end
    end

    sync_fifo #(.W(pDATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (axis_clk),
        .rst_n     (axis_rst_n),
        .push      (wr_pend),
        .pop       (pop),
        .din       ({tag, wdata}),
        .dout      (head),
        .empty     (empty),
        .full      (full),
        .occupancy (occ)
    );
endmodule

// File: tb/tb_wb_axis_in_fifo.sv
// tb_wb_axis_in_fifo: directed self-checking bench for wb_axis_in_fifo
module tb_wb_axis_in_fifo;
    logic        clk = 0, rst_n = 1, stb = 0, cyc = 0, we = 0, ap_start = 0, tready = 0;
    logic [3:0]  sel = 0;
    logic [31:0] dat_i = 0, adr = 0, data_length = 0;
    logic [31:0] dat_o, tdata;
    logic        ack, tvalid, tlast;
    int          n_chk = 0, n_pass = 0;
    logic [32:0] q[$];
    logic [31:0] rd;
    logic        va, seen;

    always #5 clk = ~clk;

    wb_axis_in_fifo dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o), .data_length(data_length),
        .ap_start(ap_start), .ss_tvalid(tvalid), .ss_tdata(tdata),
        .ss_tlast(tlast), .ss_tready(tready)
    );

    always @(negedge clk) if (tvalid && tready) q.push_back({tlast, tdata});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r, output logic v_ack);
        logic ok;
        ok = 0; r = '0; v_ack = 0;
        @(posedge clk); #2;
        cyc = 1; stb = 1; we = w; adr = {24'h0, a}; dat_i = d; sel = s;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ack) begin ok = 1; r = dat_o; v_ack = tvalid; end
        end
        check("ack", 32'(ok), 1);
        @(posedge clk); #2;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r; logic v;
        xfer(1, a, d, 4'hF, r, v);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r; logic v;
        xfer(0, a, 0, 4'hF, r, v);
        check(tag, r, exp);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 ap_start = 1;
        @(posedge clk); #2 ap_start = 0;
    endtask

    initial begin
        #3 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_tvalid", 32'(tvalid), 0);
        check("rst_tdata", tdata, 0);
        check("rst_tlast", 32'(tlast), 0);
        check("rst_dat_o", dat_o, 0);
        @(posedge clk); #2 rst_n = 1;

        // frame of 3 with tlast on the final sample
        data_length = 3; tready = 1;
        pulse_start();
        wr(8'h80, 32'h11); wr(8'h80, 32'h22); wr(8'h80, 32'h33);
        repeat (4) @(posedge clk);
        check("t1_count", 32'(q.size()), 3);
        check("t1_d0", q[0][31:0], 32'h11); check("t1_l0", 32'(q[0][32]), 0);
        check("t1_d1", q[1][31:0], 32'h22); check("t1_l1", 32'(q[1][32]), 0);
        check("t1_d2", q[2][31:0], 32'h33); check("t1_l2", 32'(q[2][32]), 1);
        rd_chk("t1_status", 8'h88, 32'h0000_0021);

        // fill to full, fifth write waits until a pop frees space
        q.delete(); tready = 0;
        for (int i = 1; i <= 4; i++) wr(8'h80, 32'h100 + i);
        @(posedge clk); #2;
        cyc = 1; stb = 1; we = 1; adr = 32'h80; dat_i = 32'h105; sel = 4'hF;
        seen = 0;
        repeat (5) begin @(negedge clk); if (ack) seen = 1; end
        check("t2_no_ack_full", 32'(seen), 0);
        @(posedge clk); #2 tready = 1;
        @(posedge clk); #2 tready = 0;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin @(negedge clk); if (ack) seen = 1; end
        check("t2_ack_after_pop", 32'(seen), 1);
        @(posedge clk); #2 cyc = 0; stb = 0; we = 0;
        check("t2_pop_count", 32'(q.size()), 1);
        check("t2_pop_data", q[0][31:0], 32'h101);
        rd_chk("t2_status", 8'h88, 32'h0002_0032);
        q.delete(); tready = 1;
        repeat (8) @(posedge clk);
        check("t2_drain_count", 32'(q.size()), 4);
        check("t2_d0", q[0][31:0], 32'h102);
        check("t2_d1", q[1][31:0], 32'h103); check("t2_l1", 32'(q[1][32]), 1);
        check("t2_d2", q[2][31:0], 32'h104); check("t2_l2", 32'(q[2][32]), 0);
        check("t2_d3", q[3][31:0], 32'h105);

        // streaming through with ready held, no tlast when data_length is 0
        data_length = 0;
        pulse_start();
        q.delete();
        for (int i = 1; i <= 4; i++) wr(8'h80, 32'h200 + i);
        repeat (4) @(posedge clk);
        check("t3_count", 32'(q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check("t3_data", q[i][31:0], 32'h201 + i);
            check("t3_last", 32'(q[i][32]), 0);
        end
        rd_chk("t3_status", 8'h88, 32'h0004_0001);

        // byte-lane masking and push-to-stream latency
        tready = 0;
        xfer(1, 8'h80, 32'hAABB_CCDD, 4'b0101, rd, va);
        check("t4_tvalid_at_ack", 32'(va), 0);
        @(negedge clk);
        check("t4_tvalid_after", 32'(tvalid), 1);
        check("t4_tdata_mask", tdata, 32'h00BB_00DD);
        check("t4_tlast", 32'(tlast), 0);
        wr(8'h80, 32'h05);
        wr(8'h90, 32'hDEAD_BEEF);
        rd_chk("t4_read_x", 8'h80, 32'h0);
        rd_chk("t4_read_other", 8'h84, 32'h0);
        rd_chk("t4_status", 8'h88, 32'h0006_0008);
        pulse_start();
        rd_chk("t4_status_start", 8'h88, 32'h0000_0008);
        check("t4_head_kept", tdata, 32'h00BB_00DD);

        // reset in the middle of a transfer
        @(posedge clk); #2;
        cyc = 1; stb = 1; we = 1; adr = 32'h80; dat_i = 32'h77; sel = 4'hF;
        @(posedge clk); #2 rst_n = 0;
        #1;
        check("t5_ack", 32'(ack), 0);
        check("t5_tvalid", 32'(tvalid), 0);
        check("t5_dat_o", dat_o, 0);
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #2 rst_n = 1;
        rd_chk("t5_status", 8'h88, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
